syncfifo_plus: RTL and testbench

SYNCFIFO_PLUS -- requirements
Module: syncfifo_plus

---
 rtl/syncfifo_plus.sv | 126 ++++++++++++
 tb/tb_syncfifo_plus.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/syncfifo_plus.sv
// Single-clock FIFO with registered level, almost-full/empty flags and sticky
// overflow/underflow. Define SYNCFIFO_PLUS_FWFT_EN for first-word-fall-through reads.
module syncfifo_plus #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 5,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clr,
    input  logic              wdv,
    input  logic [DWIDTH-1:0] wdata,
    output logic              wfull,
    input  logic              rrq,
    output logic [DWIDTH-1:0] rdata,
    output logic              rdv,
    output logic              rempty,
    output logic [AWIDTH:0]   level,
    output logic              afull,
    output logic              aempty,
    output logic              ovf,
    output logic              udf
);

    localparam int              LP_DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] LP_DEPTH_L = (AWIDTH+1)'(LP_DEPTH);
    localparam logic [AWIDTH:0] LP_AFULL   = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] LP_AEMPTY  = (AWIDTH+1)'(AEMPTY_TH);
    localparam logic [AWIDTH:0] LP_LVL_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] LP_PTR_ONE = AWIDTH'(1);

    logic [DWIDTH-1:0] r_mem [LP_DEPTH];
    logic [AWIDTH-1:0] r_wptr;
    logic [AWIDTH-1:0] r_rptr;
    logic [AWIDTH:0]   r_level;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Status is a pure decode of the registered count, so every flag lags its cause by one edge.
    assign w_full   = (r_level == LP_DEPTH_L);
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wdv & ~w_full & ~clr;
    assign w_rd_acc = rrq & ~w_empty & ~clr;

    assign wfull  = w_full;
    assign rempty = w_empty;
    assign level  = r_level;
    assign afull  = (r_level >= LP_AFULL);
    assign aempty = (r_level <= LP_AEMPTY);
    assign ovf    = r_ovf;
    assign udf    = r_udf;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LP_LVL_ONE;
                2'b01:   r_level <= r_level - LP_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (wdv && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rrq && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Storage is never reset; the pointers alone decide which words are live.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

`ifdef SYNCFIFO_PLUS_FWFT_EN
    // Head word is presented combinationally; zero while empty so reset shows rdata=0.
    assign rdata = w_empty ? '0 : r_mem[r_rptr];
    assign rdv   = ~w_empty;
`else
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rdv;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdata <= '0;
            r_rdv   <= 1'b0;
        end else if (clr) begin
            r_rdv   <= 1'b0;
        end else begin
            r_rdv <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr];
            end
        end
    end

    assign rdata = r_rdata;
    assign rdv   = r_rdv;
`endif

endmodule

// File: tb/tb_syncfifo_plus.sv
// Directed bench for syncfifo_plus: queue-based reference model checked every
// falling edge, plus hand-computed expectations for each scenario.
module tb_syncfifo_plus;

    localparam int DEPTH = 32;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic        clr    = 1'b0;
    logic        wdv    = 1'b0;
    logic [15:0] wdata  = '0;
    logic        rrq    = 1'b0;
    logic        wfull;
    logic [15:0] rdata;
    logic        rdv;
    logic        rempty;
    logic [5:0]  level;
    logic        afull;
    logic        aempty;
    logic        ovf;
    logic        udf;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_q[$];
    logic        m_ovf   = 1'b0;
    logic        m_udf   = 1'b0;
    logic        m_rdv   = 1'b0;
    logic [15:0] m_rdata = '0;
    int          m_n;
    logic [15:0] obs[$];

    syncfifo_plus #(
        .DWIDTH   (16),
        .AWIDTH   (5),
        .AFULL_TH (28),
        .AEMPTY_TH(4)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .clr   (clr),
        .wdv   (wdv),
        .wdata (wdata),
        .wfull (wfull),
        .rrq   (rrq),
        .rdata (rdata),
        .rdv   (rdv),
        .rempty(rempty),
        .level (level),
        .afull (afull),
        .aempty(aempty),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdv   = 1'b0;
        m_rdata = '0;
    endtask

    // One rising edge of the FIFO's rules, applied to a plain queue.
    task automatic model_step();
        bit full, empty;
        if (!arst_n) return;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rdv = 1'b0;
        end else begin
            if (wdv && full)  m_ovf = 1'b1;
            if (rrq && empty) m_udf = 1'b1;
            m_rdv = 1'b0;
            if (rrq && !empty) begin
                m_rdata = m_q.pop_front();
                m_rdv   = 1'b1;
            end
            if (wdv && !full) m_q.push_back(wdata);
        end
    endtask

    always @(negedge clk) begin
        m_n = m_q.size();
        chk("level",  32'(level),  32'(m_n));
        chk("wfull",  32'(wfull),  32'(m_n == DEPTH));
        chk("rempty", 32'(rempty), 32'(m_n == 0));
        chk("afull",  32'(afull),  32'(m_n >= 28));
        chk("aempty", 32'(aempty), 32'(m_n <= 4));
        chk("ovf",    32'(ovf),    32'(m_ovf));
        chk("udf",    32'(udf),    32'(m_udf));
`ifdef SYNCFIFO_PLUS_FWFT_EN
        chk("rdv", 32'(rdv), 32'(m_n != 0));
        if (m_n != 0) chk("rdata_head", 32'(rdata), 32'(m_q[0]));
`else
        chk("rdv",   32'(rdv),   32'(m_rdv));
        chk("rdata", 32'(rdata), 32'(m_rdata));
`endif
    end

    // Inputs are applied at the next rising edge; returns 1 time unit after it.
    task automatic do_cycle(input logic w, input logic [15:0] d, input logic r, input logic c);
        wdv = w; wdata = d; rrq = r; clr = c;
`ifdef SYNCFIFO_PLUS_FWFT_EN
        if (arst_n && r && !c && !rempty) obs.push_back(rdata);
`endif
        @(posedge clk);
        model_step();
        #1;
`ifndef SYNCFIFO_PLUS_FWFT_EN
        if (rdv) obs.push_back(rdata);
`endif
        wdv = 1'b0; rrq = 1'b0; clr = 1'b0;
    endtask

    task automatic write_seq(input int first, input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 16'(first + i), 1'b0, 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_obs(input string name, input int n, input int base);
        chk({name, "_count"}, 32'(obs.size()), 32'(n));
        for (int i = 0; i < n && i < obs.size(); i++)
            chk({name, "_data"}, 32'(obs[i]), 32'(base + i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        idle(2);
        chk("rst_level",  32'(level),  0);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_wfull",  32'(wfull),  0);
        chk("rst_afull",  32'(afull),  0);
        chk("rst_rdv",    32'(rdv),    0);
        chk("rst_rdata",  32'(rdata),  0);
        arst_n = 1'b1;
        idle(1);

        // Fill 0x0001..0x0020 then drain in order.
        obs.delete();
        write_seq(1, 32);
        chk("fill_wfull", 32'(wfull), 1);
        chk("fill_level", 32'(level), 32);
        read_n(32);
        idle(2);
        chk("drain_rempty", 32'(rempty), 1);
        check_obs("order32", 32, 1);

        // Write and read together while full: read wins, write dropped.
        write_seq(1, 32);
        obs.delete();
        do_cycle(1'b1, 16'hDEAD, 1'b1, 1'b0);
        chk("ovf_level", 32'(level), 31);
        chk("ovf_flag",  32'(ovf),   1);
        chk("ovf_first_count", 32'(obs.size()), 1);
        if (obs.size() > 0) chk("ovf_first_data", 32'(obs[0]), 32'h0001);
        read_n(31);
        idle(2);
        check_obs("ovf_drain", 32, 1);
        chk("ovf_sticky", 32'(ovf), 1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf), 0);

        // Read on empty, then simultaneous write/read on empty.
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("udf_flag",  32'(udf),   1);
        chk("udf_rdv",   32'(rdv),   0);
        chk("udf_level", 32'(level), 0);
        do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk("udf_clr", 32'(udf), 0);
        do_cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("wr_on_empty_level", 32'(level), 1);
        chk("wr_on_empty_udf",   32'(udf),   1);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Threshold boundaries.
        write_seq(16'h0100, 27);
        chk("afull_27", 32'(afull), 0);
        write_seq(16'h011B, 1);
        chk("afull_28", 32'(afull), 1);
        chk("level_28", 32'(level), 28);
        read_n(23);
        chk("aempty_5", 32'(aempty), 0);
        read_n(1);
        chk("aempty_4", 32'(aempty), 1);
        chk("level_4",  32'(level),  4);
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // First-word timing into an empty FIFO.
        do_cycle(1'b1, 16'h1234, 1'b0, 1'b0);
`ifdef SYNCFIFO_PLUS_FWFT_EN
        chk("fwft_rdata", 32'(rdata), 32'h1234);
        chk("fwft_rdv",   32'(rdv),   1);
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_rempty", 32'(rempty), 1);
`else
        chk("reg_rdv_nowrite", 32'(rdv), 0);
        do_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("reg_rdv",   32'(rdv),   1);
        chk("reg_rdata", 32'(rdata), 32'h1234);
        chk("reg_rempty", 32'(rempty), 1);
        idle(1);
        chk("reg_rdv_drop", 32'(rdv),   0);
        chk("reg_hold",     32'(rdata), 32'h1234);
`endif
        do_cycle(1'b0, '0, 1'b0, 1'b1);

        // Interleaved traffic, reset pulse mid-stream, then traffic across the wrap.
        for (int k = 0; k < 20; k++) do_cycle(1'b1, 16'(16'h0200 + k), k >= 4, 1'b0);
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_level",  32'(level),  0);
        chk("arst_rempty", 32'(rempty), 1);
        chk("arst_rdv",    32'(rdv),    0);
        chk("arst_rdata",  32'(rdata),  0);
        #1;
        arst_n = 1'b1;
        obs.delete();
        for (int k = 0; k < 40; k++) do_cycle(1'b1, 16'(16'h0300 + k), k >= 8, 1'b0);
        read_n(8);
        idle(2);
        check_obs("wrap40", 40, 16'h0300);
        chk("wrap_rempty", 32'(rempty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
